pa_perips_tcm_banked: RTL and testbench

//  Parametrised, word-interleaved, multi-bank TCM: port 1 = core data (R/W, byte/half/word), port 2 = fetch (read-only).
//  Req/gnt/rvalid handshake per port; per-bank conflict arbitration with starvation guard; 1-cycle read latency.

---
 rtl/pa_perips_tcm_banked_pkg.sv | 32 +++
 rtl/pa_perips_tcm_banked_bank.sv | 37 +++
 rtl/pa_perips_tcm_banked.sv | 144 ++++++++++++++
 tb/tb_pa_perips_tcm_banked.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_perips_tcm_banked_pkg.sv
// Shared bus constants and lane-mask helper for the banked TCM.
// Used by pa_perips_tcm_banked and its bank sub-module.
package pa_perips_tcm_banked_pkg;

    localparam int ADDR_BUS_WIDTH = 32;
    localparam int DATA_BUS_WIDTH = 32;

    localparam logic [DATA_BUS_WIDTH-1:0] ZERO_WORD = '0;

    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b100;

    typedef logic [3:0] lane_mask_t;

    // Misaligned half/word accesses never spill into the next word.
    function automatic lane_mask_t byte_mask(input logic [2:0] size, input logic [1:0] lane);
        logic b;
        logic h;
        logic w;
        b = (size == SIZE_BYTE);
        h = (size == SIZE_HALF);
        w = (size == SIZE_WORD);
        case (lane)
            2'b00:   byte_mask = {w, w, w | h, w | h | b};
            2'b01:   byte_mask = 4'b0010;
            2'b10:   byte_mask = {h, 1'b1, 2'b00};
            default: byte_mask = 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/pa_perips_tcm_banked_bank.sv
// One TCM bank: single-port word RAM with 4-lane byte-enable write and
// registered read. Read data only changes on an enabled read cycle.
module pa_perips_tcm_banked_bank
    import pa_perips_tcm_banked_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int ROW_W = 12
) (
    input  logic                      i_clk,
    input  logic                      i_en,
    input  logic                      i_we,
    input  logic [3:0]                i_be,
    input  logic [ROW_W-1:0]          i_row,
    input  logic [DATA_BUS_WIDTH-1:0] i_wdata,
    output logic [DATA_BUS_WIDTH-1:0] o_rdata
);

    logic [DATA_BUS_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_BUS_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (i_be[l]) begin
                        r_mem[i_row][8*l +: 8] <= i_wdata[8*l +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_row];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pa_perips_tcm_banked.sv
// Word-interleaved multi-bank TCM: port 1 data R/W, port 2 fetch read-only,
// per-bank arbitration with port-2 starvation guard. Optional: TCM_RANGE_ERR_EN.
module pa_perips_tcm_banked
    import pa_perips_tcm_banked_pkg::*;
#(
    parameter int                        RAM_KB    = 32,
    parameter int                        NUM_BANKS = 2,
    parameter int                        MAX_STALL = 3,
    parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      req1_i,
    input  logic                      we1_i,
    input  logic [2:0]                size1_i,
    input  logic [ADDR_BUS_WIDTH-1:0] addr1_i,
    input  logic [DATA_BUS_WIDTH-1:0] data1_i,
    output logic                      gnt1_o,
    output logic                      rvalid1_o,
    output logic [DATA_BUS_WIDTH-1:0] data1_o,
    input  logic                      req2_i,
    input  logic [ADDR_BUS_WIDTH-1:0] addr2_i,
    output logic                      gnt2_o,
    output logic                      rvalid2_o,
    output logic [DATA_BUS_WIDTH-1:0] data2_o,
    output logic                      err1_o
);

    localparam int CAP_BYTES = RAM_KB * 1024;
    localparam int OFF_W     = $clog2(CAP_BYTES);
    localparam int WORD_W    = OFF_W - 2;
    localparam int LOG2B     = $clog2(NUM_BANKS);
    localparam int BANK_W    = (LOG2B > 0) ? LOG2B : 1;
    localparam int ROW_W     = WORD_W - LOG2B;
    localparam int DEPTH     = RAM_KB * 256 / NUM_BANKS;

    logic [OFF_W-1:0]          w_off1;
    logic [WORD_W-1:0]         w_word1;
    logic [WORD_W-1:0]         w_word2;
    logic [BANK_W-1:0]         w_bank1;
    logic [BANK_W-1:0]         w_bank2;
    logic [ROW_W-1:0]          w_row1;
    logic [ROW_W-1:0]          w_row2;
    lane_mask_t                w_mask1;
    logic                      w_err1;
    logic                      w_same;
    logic [3:0]                w_cnt_inc;
    logic [DATA_BUS_WIDTH-1:0] w_rdata [NUM_BANKS];

    logic                      r_rv1;
    logic                      r_rv2;
    logic                      r_err1;
    logic [BANK_W-1:0]         r_sel1;
    logic [BANK_W-1:0]         r_sel2;
    logic [DATA_BUS_WIDTH-1:0] r_hold1;
    logic [DATA_BUS_WIDTH-1:0] r_hold2;
    logic [3:0]                r_cnt;
    logic                      r_prio;

    // Truncating the offset to the capacity width gives the modulo wrap.
    assign w_off1  = OFF_W'(addr1_i - BASE_ADDR);
    assign w_word1 = w_off1[OFF_W-1:2];
    assign w_word2 = WORD_W'((addr2_i - BASE_ADDR) >> 2);
    assign w_bank1 = BANK_W'(w_word1 & WORD_W'(NUM_BANKS - 1));
    assign w_bank2 = BANK_W'(w_word2 & WORD_W'(NUM_BANKS - 1));
    assign w_row1  = ROW_W'(w_word1 >> LOG2B);
    assign w_row2  = ROW_W'(w_word2 >> LOG2B);
    assign w_mask1 = byte_mask(size1_i, w_off1[1:0]);

`ifdef TCM_RANGE_ERR_EN
    logic [ADDR_BUS_WIDTH-1:0] w_off1_full;
    assign w_off1_full = addr1_i - BASE_ADDR;
    assign w_err1 = (w_off1_full >= ADDR_BUS_WIDTH'(CAP_BYTES))
                  | ((size1_i == SIZE_HALF) & w_off1_full[0])
                  | ((size1_i == SIZE_WORD) & (|w_off1_full[1:0]));
`else
    assign w_err1 = 1'b0;
`endif

    assign w_same = req1_i & req2_i & (w_bank1 == w_bank2);
    assign gnt1_o = req1_i & ~(w_same & r_prio);
    assign gnt2_o = req2_i & ~(w_same & ~r_prio);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_hit1;
        logic w_hit2;
        assign w_hit1 = rst_n_i & gnt1_o & ~w_err1 & (w_bank1 == BANK_W'(b));
        assign w_hit2 = rst_n_i & gnt2_o & (w_bank2 == BANK_W'(b));

        pa_perips_tcm_banked_bank #(
            .DEPTH (DEPTH),
            .ROW_W (ROW_W)
        ) u_bank (
            .i_clk   (clk_i),
            .i_en    (w_hit1 | w_hit2),
            .i_we    (w_hit1 & we1_i),
            .i_be    (w_mask1),
            .i_row   (w_hit1 ? w_row1 : w_row2),
            .i_wdata (data1_i),
            .o_rdata (w_rdata[b])
        );
    end

    // Error reads return zero but still complete with rvalid.
    assign data1_o   = r_rv1 ? (r_err1 ? ZERO_WORD : w_rdata[r_sel1]) : r_hold1;
    assign data2_o   = r_rv2 ? w_rdata[r_sel2] : r_hold2;
    assign rvalid1_o = r_rv1;
    assign rvalid2_o = r_rv2;
    assign err1_o    = r_err1;
    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rv1   <= 1'b0;
            r_rv2   <= 1'b0;
            r_err1  <= 1'b0;
            r_sel1  <= '0;
            r_sel2  <= '0;
            r_hold1 <= ZERO_WORD;
            r_hold2 <= ZERO_WORD;
            r_cnt   <= 4'd0;
            r_prio  <= 1'b0;
        end else begin
            r_rv1  <= gnt1_o & ~we1_i;
            r_err1 <= gnt1_o & w_err1;
            r_rv2  <= gnt2_o;
            if (gnt1_o) r_sel1 <= w_bank1;
            if (gnt2_o) r_sel2 <= w_bank2;
            if (r_rv1) r_hold1 <= data1_o;
            if (r_rv2) r_hold2 <= data2_o;

            if (w_same && r_prio) begin
                r_prio <= 1'b0;
                r_cnt  <= 4'd0;
            end else if (w_same) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc >= 4'(MAX_STALL)) r_prio <= 1'b1;
            end else if (gnt2_o) begin
                r_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_pa_perips_tcm_banked.sv
// Self-checking bench for pa_perips_tcm_banked: directed table, corner sequences,
// and randomized traffic against a word-array reference model.
module tb_pa_perips_tcm_banked;
    import pa_perips_tcm_banked_pkg::*;

    localparam int          RAM_KB    = 32;
    localparam int          NB        = 2;
    localparam int          MAX_STALL = 3;
    localparam logic [31:0] BASE      = 32'h1000_0000;
    localparam logic [31:0] CAP       = RAM_KB * 1024;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req1_i = 1'b0;
    logic        we1_i = 1'b0;
    logic [2:0]  size1_i = SIZE_WORD;
    logic [31:0] addr1_i = BASE;
    logic [31:0] data1_i = '0;
    logic        gnt1_o;
    logic        rvalid1_o;
    logic [31:0] data1_o;
    logic        req2_i = 1'b0;
    logic [31:0] addr2_i = BASE;
    logic        gnt2_o;
    logic        rvalid2_o;
    logic [31:0] data2_o;
    logic        err1_o;

    pa_perips_tcm_banked #(
        .RAM_KB    (RAM_KB),
        .NUM_BANKS (NB),
        .MAX_STALL (MAX_STALL),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req1_i    (req1_i),
        .we1_i     (we1_i),
        .size1_i   (size1_i),
        .addr1_i   (addr1_i),
        .data1_i   (data1_i),
        .gnt1_o    (gnt1_o),
        .rvalid1_o (rvalid1_o),
        .data1_o   (data1_o),
        .req2_i    (req2_i),
        .addr2_i   (addr2_i),
        .gnt2_o    (gnt2_o),
        .rvalid2_o (rvalid2_o),
        .data2_o   (data2_o),
        .err1_o    (err1_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_last1 = '0;
    logic [31:0] exp_last2 = '0;
    logic [31:0] mdl_mem [int unsigned];

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return ((a - BASE) % CAP) >> 2;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        if (mdl_mem.exists(widx(a))) return mdl_mem[widx(a)];
        return 32'h0;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        int nbytes;
        w = mdl_read(a);
        nbytes = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        for (int l = int'(a[1:0]); l < int'(a[1:0]) + nbytes && l < 4; l++)
            w[8*l +: 8] = wd[8*l +: 8];
        mdl_mem[widx(a)] = w;
    endtask

    // Single port-1 transaction with port 2 idle; returns to posedge+1.
    task automatic p1_access(input string nm, input logic we, input logic [2:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
        req1_i = 1'b1; we1_i = we; size1_i = sz; addr1_i = addr; data1_i = wd;
        @(negedge clk_i);
        chk({nm, " gnt1"}, 32'(gnt1_o), 32'd1);
        @(posedge clk_i); #1;
        req1_i = 1'b0; we1_i = 1'b0;
        chk({nm, " rvalid1"}, 32'(rvalid1_o), 32'(!we));
        if (!we) begin
            chk({nm, " data1"}, data1_o, exp);
            exp_last1 = exp;
        end else begin
            mdl_write(addr, sz, wd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, SIZE_WORD, 32'h08, 32'h1122_3344, 32'h0};
        vecs[1]  = '{1'b1, SIZE_BYTE, 32'h0A, 32'h77AA_9988, 32'h0};
        vecs[2]  = '{1'b1, SIZE_HALF, 32'h08, 32'hDEAD_5566, 32'h0};
        vecs[3]  = '{1'b0, SIZE_WORD, 32'h08, 32'h0,         32'h11AA_5566};
        vecs[4]  = '{1'b1, SIZE_WORD, 32'h20, 32'hCAFE_F00D, 32'h0};
        vecs[5]  = '{1'b1, SIZE_BYTE, 32'h23, 32'hEE12_3456, 32'h0};
        vecs[6]  = '{1'b0, SIZE_WORD, 32'h20, 32'h0,         32'hEEFE_F00D};
        vecs[7]  = '{1'b1, SIZE_HALF, 32'h22, 32'hBEEF_1234, 32'h0};
        vecs[8]  = '{1'b1, SIZE_BYTE, 32'h21, 32'h5566_7788, 32'h0};
        vecs[9]  = '{1'b0, SIZE_WORD, 32'h20, 32'h0,         32'hBEEF_770D};
        vecs[10] = '{1'b0, SIZE_WORD, 32'h08, 32'h0,         32'h11AA_5566};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst rvalid1", 32'(rvalid1_o), 32'd0);
        chk("rst rvalid2", 32'(rvalid2_o), 32'd0);
        chk("rst data1", data1_o, 32'd0);
        chk("rst data2", data2_o, 32'd0);
        chk("rst err1", 32'(err1_o), 32'd0);
        rst_n_i = 1'b1;

        // RAM survives reset; in-flight read dropped by reset
        p1_access("t1 wr", 1'b1, SIZE_WORD, BASE, 32'hDEAD_BEEF, 32'h0);
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = BASE; rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        req1_i = 1'b0; rst_n_i = 1'b1;
        chk("t1 drop rvalid1", 32'(rvalid1_o), 32'd0);
        chk("t1 drop data1", data1_o, 32'd0);
        exp_last1 = 32'h0;
        p1_access("t1 rd", 1'b0, SIZE_WORD, BASE, 32'h0, 32'hDEAD_BEEF);
        @(posedge clk_i); #1;
        chk("t1 rvalid1 one cycle", 32'(rvalid1_o), 32'd0);
        chk("t1 data1 hold", data1_o, 32'hDEAD_BEEF);

        // Byte lane table
        for (int i = 0; i < 11; i++)
            p1_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, BASE + vecs[i].off,
                      vecs[i].wdata, vecs[i].exp);

        // Parallel access to different banks
        p1_access("t3 wr", 1'b1, SIZE_WORD, BASE + 32'h4, 32'h0404_0404, 32'h0);
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = BASE;
        req2_i = 1'b1; addr2_i = BASE + 32'h4;
        @(negedge clk_i);
        chk("t3 gnt1", 32'(gnt1_o), 32'd1);
        chk("t3 gnt2", 32'(gnt2_o), 32'd1);
        @(posedge clk_i); #1;
        req1_i = 1'b0; req2_i = 1'b0;
        chk("t3 rvalid1", 32'(rvalid1_o), 32'd1);
        chk("t3 rvalid2", 32'(rvalid2_o), 32'd1);
        chk("t3 data1", data1_o, 32'hDEAD_BEEF);
        chk("t3 data2", data2_o, 32'h0404_0404);
        exp_last1 = 32'hDEAD_BEEF;
        exp_last2 = 32'h0404_0404;

        // Starvation guard: both ports hammer bank 0
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = BASE;
        req2_i = 1'b1; addr2_i = BASE + 32'h8;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            chk($sformatf("t4 gnt2 c%0d", c), 32'(gnt2_o), 32'((c % 4) == 3));
            chk($sformatf("t4 gnt1 c%0d", c), 32'(gnt1_o), 32'((c % 4) != 3));
            @(posedge clk_i); #1;
            chk($sformatf("t4 rvalid2 c%0d", c), 32'(rvalid2_o), 32'((c % 4) == 3));
            chk($sformatf("t4 data2 c%0d", c), data2_o, ((c % 4) == 3) ? 32'h11AA_5566 : exp_last2);
            if ((c % 4) == 3) exp_last2 = 32'h11AA_5566;
        end
        req1_i = 1'b0; req2_i = 1'b0;
        exp_last1 = 32'hDEAD_BEEF;

        // Read-after-write, back to back across ports
        p1_access("t5 wr", 1'b1, SIZE_WORD, BASE + 32'h10, 32'h1234_5678, 32'h0);
        req2_i = 1'b1; addr2_i = BASE + 32'h10;
        @(negedge clk_i);
        chk("t5 gnt2", 32'(gnt2_o), 32'd1);
        @(posedge clk_i); #1;
        req2_i = 1'b0;
        chk("t5 rvalid2", 32'(rvalid2_o), 32'd1);
        chk("t5 data2", data2_o, 32'h1234_5678);
        exp_last2 = 32'h1234_5678;

`ifdef TCM_RANGE_ERR_EN
        // Out-of-range write is dropped and flagged
        req1_i = 1'b1; we1_i = 1'b1; size1_i = SIZE_WORD; addr1_i = BASE + CAP; data1_i = 32'h0BAD_F00D;
        @(negedge clk_i);
        chk("t6 gnt1", 32'(gnt1_o), 32'd1);
        @(posedge clk_i); #1;
        req1_i = 1'b0; we1_i = 1'b0;
        chk("t6 err1 pulse", 32'(err1_o), 32'd1);
        chk("t6 wr rvalid1", 32'(rvalid1_o), 32'd0);
        chk("t6 wr data1 hold", data1_o, exp_last1);
        @(posedge clk_i); #1;
        chk("t6 err1 clear", 32'(err1_o), 32'd0);
        req1_i = 1'b1; size1_i = SIZE_HALF; addr1_i = BASE + 32'h1;
        @(posedge clk_i); #1;
        req1_i = 1'b0;
        chk("t6 misalign err1", 32'(err1_o), 32'd1);
        chk("t6 misalign rvalid1", 32'(rvalid1_o), 32'd1);
        chk("t6 misalign data1", data1_o, 32'h0);
        exp_last1 = 32'h0;
        p1_access("t6 rd", 1'b0, SIZE_WORD, BASE, 32'h0, 32'hDEAD_BEEF);
`else
        // Without the range check, offsets wrap modulo capacity
        p1_access("t6 wrap wr", 1'b1, SIZE_WORD, BASE + CAP, 32'h0BAD_F00D, 32'h0);
        chk("t6 err1 tied", 32'(err1_o), 32'd0);
        p1_access("t6 wrap rd", 1'b0, SIZE_WORD, BASE, 32'h0, 32'h0BAD_F00D);
`endif

        // Randomized traffic over words 16..31
        for (int w = 16; w < 32; w++)
            p1_access("rnd init", 1'b1, SIZE_WORD, BASE + 32'(w * 4), $urandom, 32'h0);
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = BASE + 32'h40;
        req2_i = 1'b1; addr2_i = BASE + 32'h44;
        @(posedge clk_i); #1;
        req1_i = 1'b0; req2_i = 1'b0;
        chk("rnd pre data1", data1_o, mdl_read(BASE + 32'h40));
        chk("rnd pre data2", data2_o, mdl_read(BASE + 32'h44));
        exp_last1 = mdl_read(BASE + 32'h40);
        exp_last2 = mdl_read(BASE + 32'h44);

        begin
            int  losses;
            bit  prio;
            bit  hold1, hold2, e_g1, e_g2, e_rv1, e_rv2, same;
            logic [31:0] e_d1, e_d2;
            losses = 0; prio = 0; hold1 = 0; hold2 = 0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                if (!hold1) begin
                    int sel;
                    int lane;
                    sel = $urandom_range(0, 2);
                    size1_i = (sel == 0) ? SIZE_BYTE : (sel == 1) ? SIZE_HALF : SIZE_WORD;
                    lane = (sel == 0) ? $urandom_range(0, 3) : (sel == 1) ? 2 * $urandom_range(0, 1) : 0;
                    req1_i = ($urandom_range(0, 3) != 0);
                    we1_i = $urandom_range(0, 1) == 1;
                    addr1_i = BASE + 32'($urandom_range(16, 31) * 4 + lane);
                    data1_i = $urandom;
                end
                if (!hold2) begin
                    req2_i = ($urandom_range(0, 2) != 0);
                    addr2_i = BASE + 32'($urandom_range(16, 31) * 4);
                end
                same = req1_i && req2_i && ((widx(addr1_i) % NB) == (widx(addr2_i) % NB));
                if (same && prio) begin
                    e_g1 = 0; e_g2 = 1; prio = 0; losses = 0;
                end else if (same) begin
                    e_g1 = 1; e_g2 = 0; losses++;
                    if (losses >= MAX_STALL) prio = 1;
                end else begin
                    e_g1 = req1_i; e_g2 = req2_i;
                    if (e_g2) losses = 0;
                end
                @(negedge clk_i);
                chk($sformatf("rnd%0d gnt1", cyc), 32'(gnt1_o), 32'(e_g1));
                chk($sformatf("rnd%0d gnt2", cyc), 32'(gnt2_o), 32'(e_g2));
                e_rv1 = e_g1 && !we1_i;
                e_rv2 = e_g2;
                e_d1 = e_rv1 ? mdl_read(addr1_i) : exp_last1;
                e_d2 = e_rv2 ? mdl_read(addr2_i) : exp_last2;
                if (e_g1 && we1_i) mdl_write(addr1_i, size1_i, data1_i);
                hold1 = req1_i && !e_g1;
                hold2 = req2_i && !e_g2;
                @(posedge clk_i); #1;
                chk($sformatf("rnd%0d rvalid1", cyc), 32'(rvalid1_o), 32'(e_rv1));
                chk($sformatf("rnd%0d rvalid2", cyc), 32'(rvalid2_o), 32'(e_rv2));
                chk($sformatf("rnd%0d data1", cyc), data1_o, e_d1);
                chk($sformatf("rnd%0d data2", cyc), data2_o, e_d2);
                exp_last1 = e_d1;
                exp_last2 = e_d2;
            end
            req1_i = 1'b0; req2_i = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
